// File: rtl/cpu_pc_stack.sv
// ---------------------------------------------------------------------------
// cpu_pc_stack
//
// Program counter for the one-cycle CPU. It supports:
//   - plain increment (wraps modulo 2^WIDTH)
//   - absolute jump (LD / ADDR)
//   - relative branch (BR / OFFSET, two's complement)
//   - hardware call/return stack (CALL pushes PC+1 and jumps, RET pops)
//   - a stall input (EN = 0 holds everything except error clearing)
//   - sticky overflow/underflow error flags
//
// When EN = 1, the strobes are resolved with a fixed priority:
//   RET > CALL > LD > BR > increment
// Lower-priority strobes in the same cycle are ignored.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset
//   EN       advance enable (0 = stall)
//   LD       absolute jump to ADDR
//   ADDR     jump / call target
//   BR       relative branch by OFFSET
//   OFFSET   two's-complement branch offset
//   CALL     push PC+1 and jump to ADDR
//   RET      pop return address into PC
//   CLR_ERR  clear the sticky error flags (also works while stalled)
//   PC_OUT   current PC (registered)
//   DEPTH    number of valid stack entries (registered)
//   FULL     DEPTH == STACK_DEPTH
//   EMPTY    DEPTH == 0
//   OVF      sticky: CALL attempted while FULL
//   UNF      sticky: RET attempted while EMPTY
// ---------------------------------------------------------------------------
module cpu_pc_stack #(
  parameter int               WIDTH       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VEC     = {WIDTH{1'b0}}
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               EN,
  input  logic                               LD,
  input  logic [WIDTH-1:0]                   ADDR,
  input  logic                               BR,
  input  logic [WIDTH-1:0]                   OFFSET,
  input  logic                               CALL,
  input  logic                               RET,
  input  logic                               CLR_ERR,
  output logic [WIDTH-1:0]                   PC_OUT,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   DEPTH,
  output logic                               FULL,
  output logic                               EMPTY,
  output logic                               OVF,
  output logic                               UNF
);

  // Depth counter width: it must be able to hold the value STACK_DEPTH itself.
  localparam int DW = $clog2(STACK_DEPTH + 1);
  // Stack index width: at least one bit, even for a single-entry stack.
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [DW-1:0]    DEPTH_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]    DEPTH_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    DEPTH_MAX  = DW'(STACK_DEPTH);
  localparam logic [WIDTH-1:0] PC_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Resolved operation for the current cycle. Error cases get their own
  // codes so the next-state logic never has to re-examine the stack level.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,  // stalled
    OP_INC  = 3'd1,  // PC + 1
    OP_BR   = 3'd2,  // PC + OFFSET
    OP_LD   = 3'd3,  // PC = ADDR
    OP_PUSH = 3'd4,  // CALL with room on the stack
    OP_OVF  = 3'd5,  // CALL while full: behaves as increment, flags OVF
    OP_POP  = 3'd6,  // RET with a valid entry
    OP_UNF  = 3'd7   // RET while empty: behaves as increment, flags UNF
  } op_e;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_r;
  logic [DW-1:0]    depth_r;
  logic             ovf_r;
  logic             unf_r;
  // Return-address storage; contents are don't-care out of reset and are
  // only ever read below the current depth, so no reset is needed.
  logic [WIDTH-1:0] stack_r [STACK_DEPTH];

  // ------------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------------
  op_e              op_s;
  logic             full_s;
  logic             empty_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] pc_br_s;
  logic [DW-1:0]    depth_dec_s;
  logic [DW-1:0]    depth_inc_s;
  logic [SW-1:0]    top_idx_s;
  logic [SW-1:0]    push_idx_s;
  logic [WIDTH-1:0] top_s;

  logic [WIDTH-1:0] pc_nxt_s;
  logic [DW-1:0]    depth_nxt_s;
  logic             push_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;

  assign full_s      = (depth_r == DEPTH_MAX);
  assign empty_s     = (depth_r == DEPTH_ZERO);
  assign pc_inc_s    = pc_r + PC_ONE;
  // Same-width addition gives sign extension and modulo wrap for free.
  assign pc_br_s     = pc_r + OFFSET;
  assign depth_dec_s = depth_r - DEPTH_ONE;
  assign depth_inc_s = depth_r + DEPTH_ONE;
  // The top valid entry sits at depth-1; a new entry goes to index depth.
  assign top_idx_s   = depth_dec_s[SW-1:0];
  assign push_idx_s  = depth_r[SW-1:0];
  // Only consumed on OP_POP, which requires depth > 0, so an unwritten
  // entry can never reach the PC.
  assign top_s       = stack_r[top_idx_s];

  // Strobe priority decode: RET > CALL > LD > BR > increment, gated by EN.
  always_comb begin
    op_s = OP_HOLD;
    if (!EN) begin
      op_s = OP_HOLD;
    end else if (RET) begin
      if (empty_s) begin
        op_s = OP_UNF;
      end else begin
        op_s = OP_POP;
      end
    end else if (CALL) begin
      if (full_s) begin
        op_s = OP_OVF;
      end else begin
        op_s = OP_PUSH;
      end
    end else if (LD) begin
      op_s = OP_LD;
    end else if (BR) begin
      op_s = OP_BR;
    end else begin
      op_s = OP_INC;
    end
  end

  // Next PC, next depth and error-event generation for the resolved operation.
  always_comb begin
    pc_nxt_s    = pc_r;
    depth_nxt_s = depth_r;
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    case (op_s)
      OP_HOLD: begin
        pc_nxt_s    = pc_r;
        depth_nxt_s = depth_r;
      end
      OP_INC: begin
        pc_nxt_s = pc_inc_s;
      end
      OP_BR: begin
        pc_nxt_s = pc_br_s;
      end
      OP_LD: begin
        pc_nxt_s = ADDR;
      end
      OP_PUSH: begin
        pc_nxt_s    = ADDR;
        depth_nxt_s = depth_inc_s;
        push_s      = 1'b1;
      end
      OP_OVF: begin
        // Rejected call: no jump, no push, existing entries untouched.
        pc_nxt_s  = pc_inc_s;
        ovf_set_s = 1'b1;
      end
      OP_POP: begin
        pc_nxt_s    = top_s;
        depth_nxt_s = depth_dec_s;
      end
      OP_UNF: begin
        pc_nxt_s  = pc_inc_s;
        unf_set_s = 1'b1;
      end
      default: begin
        pc_nxt_s    = pc_r;
        depth_nxt_s = depth_r;
      end
    endcase
  end

  // Sticky flag update: a new error event wins over a coincident clear, and
  // the clear is honoured even while stalled.
  always_comb begin
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (CLR_ERR) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
    if (unf_set_s) begin
      unf_nxt_s = 1'b1;
    end else if (CLR_ERR) begin
      unf_nxt_s = 1'b0;
    end else begin
      unf_nxt_s = unf_r;
    end
  end

  // ------------------------------------------------------------------------
  // Sequential state
  // ------------------------------------------------------------------------

  // PC, depth and error flags; reset returns to the reset vector with an
  // empty stack, discarding any call sequence in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_r    <= RST_VEC;
      depth_r <= DEPTH_ZERO;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      depth_r <= depth_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Return-address write: the pushed value is PC+1, which wraps to 0 at max.
  always_ff @(posedge CLK) begin
    if (push_s && !RST) begin
      stack_r[push_idx_s] <= pc_inc_s;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign PC_OUT = pc_r;
  assign DEPTH  = depth_r;
  assign FULL   = full_s;
  assign EMPTY  = empty_s;
  assign OVF    = ovf_r;
  assign UNF    = unf_r;

endmodule

// File: tb/tb_cpu_pc_stack.sv
// ---------------------------------------------------------------------------
// tb_cpu_pc_stack
//
// Directed bench for cpu_pc_stack (WIDTH=8, STACK_DEPTH=4, RST_VEC=0).
// The driver applies one vector per cycle on the falling edge and queues the
// hand-computed state expected after the next rising edge. A separate
// monitor wakes just after every rising CLK edge (and just after a rising
// RST edge, to observe the asynchronous reset) and compares against the
// head of the queue.
// ---------------------------------------------------------------------------
module tb_cpu_pc_stack;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       LD;
  logic [7:0] ADDR;
  logic       BR;
  logic [7:0] OFFSET;
  logic       CALL;
  logic       RET;
  logic       CLR_ERR;
  logic [7:0] PC_OUT;
  logic [2:0] DEPTH;
  logic       FULL;
  logic       EMPTY;
  logic       OVF;
  logic       UNF;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  cpu_pc_stack #(
    .WIDTH      (8),
    .STACK_DEPTH(4),
    .RST_VEC    (8'h00)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .LD     (LD),
    .ADDR   (ADDR),
    .BR     (BR),
    .OFFSET (OFFSET),
    .CALL   (CALL),
    .RET    (RET),
    .CLR_ERR(CLR_ERR),
    .PC_OUT (PC_OUT),
    .DEPTH  (DEPTH),
    .FULL   (FULL),
    .EMPTY  (EMPTY),
    .OVF    (OVF),
    .UNF    (UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Queue one expected state; FULL/EMPTY follow from the expected depth.
  task automatic expect_state(input string name, input logic [7:0] pc,
                              input logic [2:0] depth, input logic ovf,
                              input logic unf);
    exp_t e;
    e.name  = name;
    e.pc    = pc;
    e.depth = depth;
    e.full  = (depth == 3'd4);
    e.empty = (depth == 3'd0);
    e.ovf   = ovf;
    e.unf   = unf;
    exp_q.push_back(e);
  endtask

  // One clocked vector: drive on the falling edge, expect after the next rise.
  task automatic step(input string name,
                      input logic en, input logic ld, input logic [7:0] addr,
                      input logic br, input logic [7:0] off,
                      input logic call, input logic ret, input logic clr,
                      input logic [7:0] epc, input logic [2:0] edepth,
                      input logic eovf, input logic eunf);
    @(negedge CLK);
    RST     = 1'b0;
    EN      = en;
    LD      = ld;
    ADDR    = addr;
    BR      = br;
    OFFSET  = off;
    CALL    = call;
    RET     = ret;
    CLR_ERR = clr;
    expect_state(name, epc, edepth, eovf, eunf);
  endtask

  // Raise RST between clock edges; the monitor checks the reset state
  // before the next rising edge. RST is released by the next step().
  task automatic pulse_reset(input string name);
    @(negedge CLK);
    EN      = 1'b1;
    LD      = 1'b0;
    BR      = 1'b0;
    CALL    = 1'b0;
    RET     = 1'b0;
    CLR_ERR = 1'b0;
    #1;
    expect_state(name, 8'h00, 3'd0, 1'b0, 1'b0);
    RST = 1'b1;
  endtask

  // Monitor: compare the DUT state with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or posedge RST);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (PC_OUT === e.pc && DEPTH === e.depth && FULL === e.full &&
            EMPTY === e.empty && OVF === e.ovf && UNF === e.unf) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, expected pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                   e.name, PC_OUT, DEPTH, FULL, EMPTY, OVF, UNF,
                   e.pc, e.depth, e.full, e.empty, e.ovf, e.unf);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    RST = 1'b0; EN = 1'b0; LD = 1'b0; ADDR = 8'h00; BR = 1'b0;
    OFFSET = 8'h00; CALL = 1'b0; RET = 1'b0; CLR_ERR = 1'b0;

    pulse_reset("reset");
    //         name         en    ld    addr   br    off    call  ret   clr   pc     dep   ovf   unf
    // Increment and wrap
    step("inc1",       1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    step("inc2",       1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 3'd0, 1'b0, 1'b0);
    step("inc3",       1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 3'd0, 1'b0, 1'b0);
    step("ld_fe",      1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b0, 1'b0);
    step("inc_ff",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0);
    step("inc_wrap",   1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // Jump and branch
    step("ld_a7",      1'b1, 1'b1, 8'hA7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA7, 3'd0, 1'b0, 1'b0);
    step("br_m3",      1'b1, 1'b0, 8'h00, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 8'hA4, 3'd0, 1'b0, 1'b0);
    step("br_p5",      1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'hA9, 3'd0, 1'b0, 1'b0);
    step("ld_02",      1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 3'd0, 1'b0, 1'b0);
    step("br_wrap",    1'b1, 1'b0, 8'h00, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b0, 1'b0);
    // Nested call/return
    step("ld_10",      1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0);
    step("call_40",    1'b1, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 3'd1, 1'b0, 1'b0);
    step("inc_41",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 3'd1, 1'b0, 1'b0);
    step("call_80",    1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 3'd2, 1'b0, 1'b0);
    step("ret_42",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 3'd1, 1'b0, 1'b0);
    step("ret_11",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 3'd0, 1'b0, 1'b0);
    // Fill the stack, overflow, drain, underflow
    step("fill1",      1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0);
    step("fill2",      1'b1, 1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h30, 3'd2, 1'b0, 1'b0);
    step("fill3",      1'b1, 1'b0, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h50, 3'd3, 1'b0, 1'b0);
    step("fill4_full", 1'b1, 1'b0, 8'h60, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h60, 3'd4, 1'b0, 1'b0);
    step("call_ovf",   1'b1, 1'b0, 8'h70, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h61, 3'd4, 1'b1, 1'b0);
    step("drain1",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h51, 3'd3, 1'b1, 1'b0);
    step("drain2",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h31, 3'd2, 1'b1, 1'b0);
    step("drain3",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd1, 1'b1, 1'b0);
    step("drain4",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h12, 3'd0, 1'b1, 1'b0);
    step("ret_unf",    1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h13, 3'd0, 1'b1, 1'b1);
    step("clr_err",    1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h14, 3'd0, 1'b0, 1'b0);
    step("unf_set_win",1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h15, 3'd0, 1'b0, 1'b1);
    step("clr_stalled",1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h15, 3'd0, 1'b0, 1'b0);
    // Stall and priority
    step("call_90",    1'b1, 1'b0, 8'h90, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h90, 3'd1, 1'b0, 1'b0);
    step("stall1",     1'b0, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h90, 3'd1, 1'b0, 1'b0);
    step("stall2",     1'b0, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h90, 3'd1, 1'b0, 1'b0);
    step("stall3",     1'b0, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h90, 3'd1, 1'b0, 1'b0);
    step("call_ld_br", 1'b1, 1'b1, 8'hC0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'hC0, 3'd2, 1'b0, 1'b0);
    step("ret_91",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h91, 3'd1, 1'b0, 1'b0);
    step("ret_call",   1'b1, 1'b0, 8'hE0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h16, 3'd0, 1'b0, 1'b0);
    step("ld_over_br", 1'b1, 1'b1, 8'h33, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h33, 3'd0, 1'b0, 1'b0);
    // Call at PC max pushes 0
    step("ld_ff",      1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0);
    step("call_at_ff", 1'b1, 1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 3'd1, 1'b0, 1'b0);
    step("ret_to_00",  1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step("stall_ret",  1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // Build DEPTH=3, PC=55 with a flag set, then reset between edges
    step("ret_unf2",   1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0, 1'b1);
    step("pre_call1",  1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 3'd1, 1'b0, 1'b1);
    step("pre_call2",  1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 3'd2, 1'b0, 1'b1);
    step("pre_call3",  1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 3'd3, 1'b0, 1'b1);
    pulse_reset("async_rst");
    step("post_rst",   1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    step("post_rst_ret",1'b1,1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 3'd0, 1'b0, 1'b1);
    step("br_neg_big", 1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h82, 3'd0, 1'b0, 1'b1);

    // Idle and let the monitor drain the queue.
    @(negedge CLK);
    EN = 1'b0; LD = 1'b0; BR = 1'b0; CALL = 1'b0; RET = 1'b0; CLR_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    chk_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL queue_drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
